// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, register index and writeback queue entry.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef struct packed {
    logic     live;
    regbits_t wsel;
    word_t    wdat;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Secondary writeback queue: circular storage with per-entry live bits, kill-by-register
// and a youngest-live-match lookup for the two decode read ports.
module regfile_wb_fifo
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   push,
  input  regbits_t               push_wsel,
  input  word_t                  push_wdat,
  input  logic                   pop,
  input  logic                   kill,
  input  regbits_t               kill_wsel,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  input  regbits_t               lk_sel1,
  input  regbits_t               lk_sel2,
  output logic                   lk_hit1,
  output logic                   lk_hit2,
  output word_t                  lk_dat1,
  output word_t                  lk_dat2
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  assign head = mem[rd_ptr];

  // Kill is applied before the push so a same-cycle push is stored live.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem[PTR_W'(i)] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (kill) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (mem[PTR_W'(i)].live && (mem[PTR_W'(i)].wsel == kill_wsel))
            mem[PTR_W'(i)].live <= 1'b0;
        end
      end
      if (pop) begin
        mem[rd_ptr].live <= 1'b0;
        rd_ptr           <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        mem[wr_ptr] <= '{live: 1'b1, wsel: push_wsel, wdat: push_wdat};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to youngest so the last hit is the youngest match.
  always_comb begin
    lk_hit1 = 1'b0;
    lk_hit2 = 1'b0;
    lk_dat1 = '0;
    lk_dat2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && mem[rd_ptr + PTR_W'(i)].live) begin
        if (mem[rd_ptr + PTR_W'(i)].wsel == lk_sel1) begin
          lk_hit1 = 1'b1;
          lk_dat1 = mem[rd_ptr + PTR_W'(i)].wdat;
        end
        if (mem[rd_ptr + PTR_W'(i)].wsel == lk_sel2) begin
          lk_hit2 = 1'b1;
          lk_dat2 = mem[rd_ptr + PTR_W'(i)].wdat;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: primary WB pass-through, secondary writes queued and
// drained in idle slots, with in-flight data forwarded onto the decode read ports.
module regfile_write_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   pri_wen,
  input  regbits_t               pri_wsel,
  input  word_t                  pri_wdat,
  input  logic                   sec_valid,
  output logic                   sec_ready,
  input  regbits_t               sec_wsel,
  input  word_t                  sec_wdat,
  output logic                   rf_WEN,
  output regbits_t               rf_wsel,
  output word_t                  rf_wdat,
  input  regbits_t               rsel1,
  input  regbits_t               rsel2,
  input  word_t                  rf_rdat1,
  input  word_t                  rf_rdat2,
  output word_t                  rdat1,
  output word_t                  rdat2,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic      pri_act;
  logic      drain;
  logic      push;
  wb_entry_t head;
  logic      lk_hit1;
  logic      lk_hit2;
  word_t     lk_dat1;
  word_t     lk_dat2;

  // A primary write to R0 is a no-op and leaves the slot free for draining.
  assign pri_act   = pri_wen && (pri_wsel != '0);
  assign drain     = !pri_act && (fifo_count != '0);
  assign sec_ready = (fifo_count != CNT_W'(DEPTH));
  assign push      = sec_valid && sec_ready && (sec_wsel != '0);

  regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (push),
    .push_wsel (sec_wsel),
    .push_wdat (sec_wdat),
    .pop       (drain),
    .kill      (pri_act),
    .kill_wsel (pri_wsel),
    .head      (head),
    .count     (fifo_count),
    .lk_sel1   (rsel1),
    .lk_sel2   (rsel2),
    .lk_hit1   (lk_hit1),
    .lk_hit2   (lk_hit2),
    .lk_dat1   (lk_dat1),
    .lk_dat2   (lk_dat2)
  );

  // Write port mux; a killed head still consumes its slot but writes nothing.
  always_comb begin
    rf_WEN  = 1'b0;
    rf_wsel = '0;
    rf_wdat = '0;
    if (pri_act) begin
      rf_WEN  = 1'b1;
      rf_wsel = pri_wsel;
      rf_wdat = pri_wdat;
    end else if (drain && head.live) begin
      rf_WEN  = 1'b1;
      rf_wsel = head.wsel;
      rf_wdat = head.wdat;
    end
  end

  // Forwarding priority: R0, then primary, then youngest queued, then regfile.
  always_comb begin
    rdat1 = rf_rdat1;
    if (rsel1 == '0)                        rdat1 = '0;
    else if (pri_act && (pri_wsel == rsel1)) rdat1 = pri_wdat;
    else if (lk_hit1)                        rdat1 = lk_dat1;
  end

  always_comb begin
    rdat2 = rf_rdat2;
    if (rsel2 == '0)                        rdat2 = '0;
    else if (pri_act && (pri_wsel == rsel2)) rdat2 = pri_wdat;
    else if (lk_hit2)                        rdat2 = lk_dat2;
  end

endmodule
